sd_stream_scheduler: RTL and testbench

SD_STREAM_SCHEDULER -- requirements
Module: sd_stream_scheduler

---
 rtl/sd_stream_pkg.sv | 23 ++
 rtl/sd_timeout_counter.sv | 32 +++
 rtl/sd_stream_scheduler.sv | 157 +++++++++++++++
 tb/tb_sd_stream_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_stream_pkg.sv
// Shared types and song address table for the SD streaming scheduler.
package sd_stream_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      WAIT_SPACE,
      DRAIN
   } state_e;

   localparam int unsigned BLOCK_BYTES = 512;
   localparam int unsigned NUM_SONGS   = 4;

   // Byte addresses on the card; end is exclusive, start==end still plays one block.
   localparam logic [31:0] SONG_START [NUM_SONGS] = '{
      32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_4000
   };
   localparam logic [31:0] SONG_END [NUM_SONGS] = '{
      32'h0000_0800, 32'h0000_1400, 32'h0000_2000, 32'h0000_8000
   };

endpackage

// File: rtl/sd_timeout_counter.sv
// Watchdog counter: cleared on request, counts while enabled, flags the last cycle.
module sd_timeout_counter #(
   parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
   input  logic clk_25mhz,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign expired_o = enable_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (enable_i && !expired_o)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk_25mhz) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/sd_stream_scheduler.sv
// Schedules SD block reads for one song into the audio FIFO.
// Define SD_STREAM_LOOP_EN to replay the song continuously until stop or timeout.
module sd_stream_scheduler
   import sd_stream_pkg::*;
#(
   parameter int unsigned ADDR_STEP   = 512,
   parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
   input  logic        clk_25mhz,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic [1:0]  song_sel,
   input  logic        sd_data_valid,
   input  logic        sd_done,
   input  logic        fifo_prog_empty,
   input  logic        fifo_full,
   output logic        read_block,
   output logic [31:0] sd_addr,
   output logic        fifo_wr_en,
   output logic        stream_active,
   output logic        first_block_ready,
   output logic        overflow_err,
   output logic        timeout_err
);

   state_e      state_q, state_d;
   logic [31:0] sd_addr_q, sd_addr_d, end_addr_q, end_addr_d;
   logic [31:0] next_addr;
   logic        read_block_q, read_block_d;
   logic        active_q, active_d, fbr_q, fbr_d;
   logic        ovf_q, ovf_d, tmo_q, tmo_d, pstop_q, pstop_d;
   logic        tmo_clear, tmo_en, tmo_expired;
`ifdef SD_STREAM_LOOP_EN
   logic [31:0] start_addr_q, start_addr_d;
`endif

   sd_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
      .clk_25mhz (clk_25mhz),
      .rst       (rst),
      .clear_i   (tmo_clear),
      .enable_i  (tmo_en),
      .expired_o (tmo_expired)
   );

   assign next_addr         = sd_addr_q + 32'(ADDR_STEP);
   assign read_block        = read_block_q;
   assign sd_addr           = sd_addr_q;
   assign stream_active     = active_q;
   assign first_block_ready = fbr_q;
   assign overflow_err      = ovf_q;
   assign timeout_err       = tmo_q;
   assign fifo_wr_en        = sd_data_valid & ~fifo_full & active_q & ~rst;

   always_comb begin
      state_d      = state_q;
      sd_addr_d    = sd_addr_q;
      end_addr_d   = end_addr_q;
      read_block_d = 1'b0;
      active_d     = active_q;
      fbr_d        = fbr_q;
      tmo_d        = tmo_q;
      pstop_d      = pstop_q;
      tmo_clear    = 1'b0;
      tmo_en       = 1'b0;
      ovf_d        = ovf_q | (sd_data_valid & fifo_full);
`ifdef SD_STREAM_LOOP_EN
      start_addr_d = start_addr_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            sd_addr_d  = SONG_START[song_sel];
            end_addr_d = SONG_END[song_sel];
`ifdef SD_STREAM_LOOP_EN
            start_addr_d = SONG_START[song_sel];
`endif
            active_d   = 1'b1;
            pstop_d    = 1'b0;
            state_d    = ISSUE;
         end
         ISSUE: if (stop) begin
            state_d = DRAIN;
         end else begin
            read_block_d = 1'b1;
            tmo_clear    = 1'b1;
            state_d      = WAIT_DONE;
         end
         WAIT_DONE: begin
            tmo_en = 1'b1;
            if (sd_done) begin
               fbr_d = 1'b1;
               // The transfer that was in flight completes, but a stop keeps the address.
               if (stop || pstop_q) begin
                  state_d = DRAIN;
               end else begin
                  sd_addr_d = next_addr;
                  state_d   = WAIT_SPACE;
                  if (next_addr >= end_addr_q) begin
`ifdef SD_STREAM_LOOP_EN
                     sd_addr_d = start_addr_q;
`else
                     state_d   = DRAIN;
`endif
                  end
               end
            end else if (tmo_expired) begin
               tmo_d   = 1'b1;
               state_d = DRAIN;
            end else if (stop) begin
               pstop_d = 1'b1;
            end
         end
         WAIT_SPACE: begin
            if (stop)                 state_d = DRAIN;
            else if (fifo_prog_empty) state_d = ISSUE;
         end
         DRAIN: begin
            active_d = 1'b0;
            fbr_d    = 1'b0;
            pstop_d  = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_25mhz) begin
      if (rst) begin
         state_q      <= IDLE;
         sd_addr_q    <= '0;
         end_addr_q   <= '0;
         read_block_q <= 1'b0;
         active_q     <= 1'b0;
         fbr_q        <= 1'b0;
         ovf_q        <= 1'b0;
         tmo_q        <= 1'b0;
         pstop_q      <= 1'b0;
`ifdef SD_STREAM_LOOP_EN
         start_addr_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         sd_addr_q    <= sd_addr_d;
         end_addr_q   <= end_addr_d;
         read_block_q <= read_block_d;
         active_q     <= active_d;
         fbr_q        <= fbr_d;
         ovf_q        <= ovf_d;
         tmo_q        <= tmo_d;
         pstop_q      <= pstop_d;
`ifdef SD_STREAM_LOOP_EN
         start_addr_q <= start_addr_d;
`endif
      end
   end

endmodule

// File: tb/tb_sd_stream_scheduler.sv
// Scoreboard bench: expected read addresses are queued by the stimulus and checked by a monitor.
module tb_sd_stream_scheduler;
   logic        clk_25mhz = 1'b0;
   logic        rst = 1'b1, start = 1'b0, stop = 1'b0, t_start = 1'b0;
   logic [1:0]  song_sel = 2'd0;
   logic        sd_data_valid = 1'b0, sd_done = 1'b0, fifo_prog_empty = 1'b1, fifo_full = 1'b0;
   logic        read_block, fifo_wr_en, stream_active, first_block_ready, overflow_err, timeout_err;
   logic [31:0] sd_addr;
   logic        t_read_block, t_fifo_wr_en, t_stream_active, t_fbr, t_overflow_err, t_timeout_err;
   logic [31:0] t_sd_addr;

   int          n_chk = 0, n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e;

   always #20 clk_25mhz = ~clk_25mhz;

   sd_stream_scheduler #(.ADDR_STEP(512), .TIMEOUT_CYC(64)) u_dut (
      .clk_25mhz(clk_25mhz), .rst(rst), .start(start), .stop(stop), .song_sel(song_sel),
      .sd_data_valid(sd_data_valid), .sd_done(sd_done), .fifo_prog_empty(fifo_prog_empty),
      .fifo_full(fifo_full), .read_block(read_block), .sd_addr(sd_addr), .fifo_wr_en(fifo_wr_en),
      .stream_active(stream_active), .first_block_ready(first_block_ready),
      .overflow_err(overflow_err), .timeout_err(timeout_err));

   // Short-watchdog instance; its sd_done stays low so the timeout path is exercised.
   sd_stream_scheduler #(.ADDR_STEP(512), .TIMEOUT_CYC(16)) u_tmo (
      .clk_25mhz(clk_25mhz), .rst(rst), .start(t_start), .stop(1'b0), .song_sel(2'd0),
      .sd_data_valid(1'b0), .sd_done(1'b0), .fifo_prog_empty(1'b1),
      .fifo_full(1'b0), .read_block(t_read_block), .sd_addr(t_sd_addr), .fifo_wr_en(t_fifo_wr_en),
      .stream_active(t_stream_active), .first_block_ready(t_fbr),
      .overflow_err(t_overflow_err), .timeout_err(t_timeout_err));

   always @(negedge clk_25mhz) begin
      if (read_block) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rb_addr: unexpected read_block at sd_addr=%0d, none expected", sd_addr);
         end else begin
            e = exp_q.pop_front();
            if (sd_addr !== e) begin
               n_fail++;
               $display("FAIL rb_addr: got sd_addr=%0d expected %0d", sd_addr, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_25mhz);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic go(input logic [1:0] sel);
      song_sel = sel;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_rb(input string name);
      int n = 0;
      while (!read_block && n < 300) begin
         tick();
         n++;
      end
      chk({name, "_rb_seen"}, {31'd0, read_block}, 32'd1);
   endtask

   task automatic sd_xfer(input int nbytes);
      for (int i = 0; i < nbytes; i++) begin
         sd_data_valid = 1'b1;
         #1;
         if (i == 0) chk("wr_en_pass", {31'd0, fifo_wr_en}, 32'd1);
         tick();
      end
      sd_data_valid = 1'b0;
      sd_done       = 1'b1;
      tick();
      sd_done       = 1'b0;
   endtask

   initial begin
      #(40 * 20000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int rb_cnt, lo_cnt, wr_cnt;
      repeat (3) tick();
      chk("rst_read_block", {31'd0, read_block}, 32'd0);
      chk("rst_sd_addr", sd_addr, 32'd0);
      chk("rst_active", {31'd0, stream_active}, 32'd0);
      chk("rst_errs", {30'd0, overflow_err, timeout_err}, 32'd0);
      rst = 1'b0;
      tick();

`ifdef SD_STREAM_LOOP_EN
      // Two-block song replays start, start+512, ... until stopped.
      exp_q.push_back(32'd4096); exp_q.push_back(32'd4608);
      exp_q.push_back(32'd4096); exp_q.push_back(32'd4608); exp_q.push_back(32'd4096);
      go(2'd1);
      for (int i = 0; i < 4; i++) begin
         wait_rb("loop");
         sd_xfer(2);
         if (i == 1) begin
            chk("loop_fbr_kept", {31'd0, first_block_ready}, 32'd1);
            chk("loop_active_kept", {31'd0, stream_active}, 32'd1);
         end
      end
      wait_rb("loop_last");
      stop = 1'b1; sd_done = 1'b1;
      tick();
      stop = 1'b0; sd_done = 1'b0;
      tick();
      chk("loop_stopped", {31'd0, stream_active}, 32'd0);
`else
      // Song 0: four blocks 0..1536, then drain with sd_addr at 2048.
      exp_q.push_back(32'd0); exp_q.push_back(32'd512);
      exp_q.push_back(32'd1024); exp_q.push_back(32'd1536);
      go(2'd0);
      chk("s0_active", {31'd0, stream_active}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         wait_rb("s0");
         sd_xfer(4);
         if (i == 0) chk("s0_fbr", {31'd0, first_block_ready}, 32'd1);
      end
      tick();
      chk("s0_end_active", {31'd0, stream_active}, 32'd0);
      chk("s0_end_fbr", {31'd0, first_block_ready}, 32'd0);
      chk("s0_end_addr", sd_addr, 32'd2048);

      // Song 2 has start==end: exactly one block then drain.
      exp_q.push_back(32'd8192);
      go(2'd2);
      wait_rb("s2");
      sd_xfer(2);
      tick();
      chk("s2_active", {31'd0, stream_active}, 32'd0);
      chk("s2_addr", sd_addr, 32'd8704);
`endif

      // Back-pressure: no read while prog_empty low, then 2-cycle latency.
      exp_q.push_back(32'd16384);
      go(2'd3);
      wait_rb("bp");
      fifo_prog_empty = 1'b0;
      sd_xfer(2);
      rb_cnt = 0;
      repeat (100) begin
         rb_cnt += int'(read_block);
         tick();
      end
      chk("bp_no_rb", rb_cnt, 32'd0);
      exp_q.push_back(32'd16896);
      fifo_prog_empty = 1'b1;
      tick();
      chk("bp_lat1", {31'd0, read_block}, 32'd0);
      tick();
      chk("bp_lat2", {31'd0, read_block}, 32'd1);

      // Stop 10 cycles into the transfer; sd_done at cycle 50 closes it out.
      lo_cnt = 0;
      for (int k = 1; k <= 52; k++) begin
         tick();
         stop    = (k == 10);
         sd_done = (k == 50);
         if (k <= 50) lo_cnt += int'(!stream_active);
         if (k == 51) chk("stop_drain_active", {31'd0, stream_active}, 32'd1);
      end
      chk("stop_wait_active", lo_cnt, 32'd0);
      chk("stop_idle_active", {31'd0, stream_active}, 32'd0);
      chk("stop_addr", sd_addr, 32'd16896);
      chk("stop_no_tmo", {31'd0, timeout_err}, 32'd0);

      // Stop coincident with sd_done: no address advance.
      exp_q.push_back(32'd4096);
      go(2'd1);
      wait_rb("sd");
      stop = 1'b1; sd_done = 1'b1;
      tick();
      stop = 1'b0; sd_done = 1'b0;
      tick();
      chk("sd_active", {31'd0, stream_active}, 32'd0);
      chk("sd_fbr", {31'd0, first_block_ready}, 32'd0);
      chk("sd_addr", sd_addr, 32'd4096);
      repeat (5) tick();

      // Overflow: three bytes into a full FIFO, sticky until a mid-transfer reset.
      exp_q.push_back(32'd0);
      go(2'd0);
      wait_rb("ovf");
      chk("ovf_clear", {31'd0, overflow_err}, 32'd0);
      fifo_full = 1'b1;
      wr_cnt = 0;
      repeat (3) begin
         sd_data_valid = 1'b1;
         #1;
         wr_cnt += int'(fifo_wr_en);
         tick();
         sd_data_valid = 1'b0;
         tick();
      end
      chk("ovf_no_wr", wr_cnt, 32'd0);
      chk("ovf_set", {31'd0, overflow_err}, 32'd1);
      fifo_full = 1'b0;
      repeat (3) tick();
      chk("ovf_sticky", {31'd0, overflow_err}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_ovf", {31'd0, overflow_err}, 32'd0);
      chk("mid_rst_active", {31'd0, stream_active}, 32'd0);
      chk("mid_rst_addr", sd_addr, 32'd0);
      tick();

      // Timeout with TIMEOUT_CYC=16 on the second instance.
      t_start = 1'b1;
      tick();
      t_start = 1'b0;
      rb_cnt = 0;
      while (!t_read_block && rb_cnt < 20) begin
         tick();
         rb_cnt++;
      end
      chk("tmo_rb_seen", {31'd0, t_read_block}, 32'd1);
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (k == 15) begin
            chk("tmo_c15_err", {31'd0, t_timeout_err}, 32'd0);
            chk("tmo_c15_active", {31'd0, t_stream_active}, 32'd1);
         end
         if (k == 16) chk("tmo_c16_err", {31'd0, t_timeout_err}, 32'd1);
      end
      chk("tmo_idle_active", {31'd0, t_stream_active}, 32'd0);
      chk("tmo_err_sticky", {31'd0, t_timeout_err}, 32'd1);

      repeat (3) tick();
      chk("sb_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
